// File: rtl/modem_ctrl_sequencer.sv
// Queued modem-line driver: applies masked {cts,dsr,ri,dcd} updates per channel, then holds.
// Optional MODEM_AUTO_CTS_EN: per-channel CTS follows a synchronised RTS. State: S_IDLE = wait for command | S_HOLD = count down hold.
`timescale 1ns/1ps
module modem_ctrl_sequencer #(
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter int          HOLD_W     = 16,
  parameter logic [3:0]  RESET_VAL  = 4'b0000,
  localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [3:0]        cmd_bits,
  input  logic [3:0]        cmd_mask,
  input  logic              cmd_auto,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              flush,
  input  logic [NUM_CH-1:0] rts_pad_o,
  output logic [NUM_CH-1:0] cts_pad_i,
  output logic [NUM_CH-1:0] dsr_pad_i,
  output logic [NUM_CH-1:0] ri_pad_i,
  output logic [NUM_CH-1:0] dcd_pad_i,
  output logic              busy,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              cmd_done,
  output logic              cmd_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [3:0]        bits;
    logic [3:0]        mask;
`ifdef MODEM_AUTO_CTS_EN
    logic              autoc;
`endif
    logic [HOLD_W-1:0] hold;
  } cmd_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              oor_q, oor_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [3:0]        line_q [NUM_CH];
  logic [3:0]        line_d [NUM_CH];
  logic [NUM_CH-1:0] auto_q, auto_d;

  cmd_t new_cmd, head;
  logic full, empty, push, pop;

  always_comb begin
    new_cmd       = '0;
    new_cmd.ch    = cmd_ch;
    new_cmd.bits  = cmd_bits;
    new_cmd.mask  = cmd_mask;
    new_cmd.hold  = cmd_hold;
`ifdef MODEM_AUTO_CTS_EN
    new_cmd.autoc = cmd_auto;
`endif
  end

  assign head      = mem_q[rd_ptr_q];
  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && !empty && !flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    oor_d    = oor_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    line_d   = line_q;
    auto_d   = auto_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_cmd;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (flush) begin
      // Abort silently: pads and auto-CTS settings stay as they are.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      state_d  = S_IDLE;
      cnt_d    = '0;
      oor_d    = 1'b0;
    end else begin
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d    = head.hold;
            oor_d    = !({1'b0, head.ch} < NUM_CH_L);
            state_d  = S_HOLD;
            for (int c = 0; c < NUM_CH; c++) begin
              if (head.ch == c[CH_W-1:0]) begin
                line_d[c] = (line_q[c] & ~head.mask) | (head.bits & head.mask);
`ifdef MODEM_AUTO_CTS_EN
                auto_d[c] = head.autoc;
`endif
              end
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = oor_q;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      oor_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      line_q   <= '{default: RESET_VAL};
      auto_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oor_q    <= oor_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      line_q   <= line_d;
      auto_q   <= auto_d;
    end
  end

`ifdef MODEM_AUTO_CTS_EN
  logic [NUM_CH-1:0] rts_s1_q, rts_s2_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rts_s1_q <= {NUM_CH{RESET_VAL[3]}};
      rts_s2_q <= {NUM_CH{RESET_VAL[3]}};
    end else begin
      rts_s1_q <= rts_pad_o;
      rts_s2_q <= rts_s1_q;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = ^{cmd_auto, rts_pad_o, auto_q};
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pad
`ifdef MODEM_AUTO_CTS_EN
    assign cts_pad_i[g] = auto_q[g] ? rts_s2_q[g] : line_q[g][3];
`else
    assign cts_pad_i[g] = line_q[g][3];
`endif
    assign dsr_pad_i[g] = line_q[g][2];
    assign ri_pad_i[g]  = line_q[g][1];
    assign dcd_pad_i[g] = line_q[g][0];
  end

  assign busy       = (state_q == S_HOLD) || !empty;
  assign fifo_level = level_q;
  assign cmd_done   = done_q;
  assign cmd_err    = err_q;
endmodule

// File: tb/tb_modem_ctrl_sequencer.sv
// Directed bench for modem_ctrl_sequencer (NUM_CH=3, FIFO_DEPTH=4, RESET_VAL=4'b1001).
`timescale 1ns/1ps
module tb_modem_ctrl_sequencer;
  localparam int NUM_CH = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int HOLD_W = 16;
  localparam logic [3:0] RESET_VAL = 4'b1001;
  localparam logic [11:0] PADS_RST = {3'b111, 3'b000, 3'b000, 3'b111};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0, flush = 1'b0, cmd_auto = 1'b0;
  logic [1:0] cmd_ch = '0;
  logic [3:0] cmd_bits = '0, cmd_mask = '0;
  logic [HOLD_W-1:0] cmd_hold = '0;
  logic [NUM_CH-1:0] rts = 3'b101;
  logic cmd_ready, busy, cmd_done, cmd_err;
  logic [NUM_CH-1:0] cts, dsr, ri, dcd;
  logic [2:0] fifo_level;

  modem_ctrl_sequencer #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .HOLD_W(HOLD_W),
                         .RESET_VAL(RESET_VAL)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_bits(cmd_bits), .cmd_mask(cmd_mask), .cmd_auto(cmd_auto),
    .cmd_hold(cmd_hold), .flush(flush), .rts_pad_o(rts), .cts_pad_i(cts),
    .dsr_pad_i(dsr), .ri_pad_i(ri), .dcd_pad_i(dcd), .busy(busy),
    .fifo_level(fifo_level), .cmd_done(cmd_done), .cmd_err(cmd_err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [3:0]  bits;
    logic [3:0]  mask;
    logic [15:0] hold;
    logic [11:0] exp_pads;   // {cts, dsr, ri, dcd} after the command applies
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];
  vec_t cmds_b [5];
  int exp_done_b [5];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cmd_valid = 1'b1;
    cmd_ch    = v.ch;
    cmd_bits  = v.bits;
    cmd_mask  = v.mask;
    cmd_hold  = v.hold;
  endtask

  function automatic logic [11:0] pads();
    return {cts, dsr, ri, dcd};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nd;
    int tdone [5];

    vecs[0] = '{2'd1, 4'b1010, 4'hF,    16'd3, {3'b111, 3'b000, 3'b010, 3'b101}, 1'b0};
    vecs[1] = '{2'd0, 4'b0110, 4'b1100, 16'd0, {3'b110, 3'b001, 3'b010, 3'b101}, 1'b0};
    vecs[2] = '{2'd2, 4'b0000, 4'b0001, 16'd2, {3'b110, 3'b001, 3'b010, 3'b001}, 1'b0};
    vecs[3] = '{2'd3, 4'b1111, 4'hF,    16'd1, {3'b110, 3'b001, 3'b010, 3'b001}, 1'b1};
    vecs[4] = '{2'd1, 4'b0101, 4'b0000, 16'd5, {3'b110, 3'b001, 3'b010, 3'b001}, 1'b0};
    vecs[5] = '{2'd2, 4'b0111, 4'b0110, 16'd1, {3'b110, 3'b101, 3'b110, 3'b001}, 1'b0};

    cmds_b[0] = '{2'd0, 4'b1111, 4'b0001, 16'd6, 12'h0, 1'b0};
    cmds_b[1] = '{2'd1, 4'b0000, 4'b0010, 16'd2, 12'h0, 1'b0};
    cmds_b[2] = '{2'd2, 4'b0000, 4'b1000, 16'd1, 12'h0, 1'b0};
    cmds_b[3] = '{2'd0, 4'b1000, 4'b1000, 16'd0, 12'h0, 1'b0};
    cmds_b[4] = '{2'd1, 4'b0100, 4'b0101, 16'd3, 12'h0, 1'b0};
    exp_done_b = '{4, 8, 11, 13, 18};

    // Reset asserted mid-cycle before the first clock edge
    #1 rst = 1'b1;
    #1;
    chk("reset_pads", 32'(pads()), 32'(PADS_RST));
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_level", 32'(fifo_level), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(cmd_done), 32'd0);
    chk("idle_pads", 32'(pads()), 32'(PADS_RST));

    // Single commands from idle, one at a time
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'd1);
      tick();
      chk($sformatf("v%0d_pads", i), 32'(pads()), 32'(vecs[i].exp_pads));
      n = 1;
      while (n <= 40) begin
        tick();
        if (cmd_done) break;
        n++;
      end
      chk($sformatf("v%0d_done_lat", i), 32'(n), 32'(vecs[i].hold + 16'd1));
      chk($sformatf("v%0d_err", i), 32'(cmd_err), 32'(vecs[i].exp_err));
    end

    // Back-to-back: fill the FIFO while the first command holds
    for (int j = 0; j < 5; j++) begin
      drive(cmds_b[j]);
      tick();
    end
    chk("b2b_ready_full", 32'(cmd_ready), 32'd0);
    chk("b2b_level_full", 32'(fifo_level), 32'd4);
    drive('{2'd0, 4'b0000, 4'hF, 16'd0, 12'h0, 1'b0});
    tick();
    chk("b2b_level_blocked", 32'(fifo_level), 32'd4);
    cmd_valid = 1'b0;
    nd = 0;
    for (int k = 2; k <= 30; k++) begin
      tick();
      if (cmd_done) begin
        if (nd < 5) tdone[nd] = k;
        nd++;
      end
    end
    chk("b2b_done_count", 32'(nd), 32'd5);
    for (int j = 0; j < 5; j++)
      chk($sformatf("b2b_done_t%0d", j), 32'(tdone[j]), 32'(exp_done_b[j]));
    chk("b2b_pads", 32'(pads()), 32'({3'b011, 3'b111, 3'b100, 3'b001}));
    chk("b2b_busy", 32'(busy), 32'd0);

    // Flush during the second command's hold, with a write offered
    drive('{2'd0, 4'b0000, 4'b0100, 16'd1, 12'h0, 1'b0});
    tick();
    drive('{2'd2, 4'b0011, 4'b0011, 16'd8, 12'h0, 1'b0});
    tick();
    drive('{2'd1, 4'b1111, 4'hF, 16'd1, 12'h0, 1'b0});
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("fl_level_pre", 32'(fifo_level), 32'd1);
    chk("fl_pads_pre", 32'(pads()), 32'({3'b011, 3'b110, 3'b100, 3'b101}));
    tick();
    drive('{2'd0, 4'b1111, 4'hF, 16'd0, 12'h0, 1'b0});
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(cmd_ready), 32'd0);
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("fl_level", 32'(fifo_level), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_pads", 32'(pads()), 32'({3'b011, 3'b110, 3'b100, 3'b101}));
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cmd_done) nd++;
    end
    chk("fl_no_done", 32'(nd), 32'd0);
    chk("fl_pads_after", 32'(pads()), 32'({3'b011, 3'b110, 3'b100, 3'b101}));

    // Asynchronous reset in the middle of a long hold
    drive('{2'd1, 4'b0000, 4'hF, 16'd20, 12'h0, 1'b0});
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rh_pads_applied", 32'(pads()), 32'({3'b001, 3'b100, 3'b100, 3'b101}));
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    chk("rh_pads", 32'(pads()), 32'(PADS_RST));
    chk("rh_level", 32'(fifo_level), 32'd0);
    chk("rh_busy", 32'(busy), 32'd0);
    chk("rh_ready", 32'(cmd_ready), 32'd1);
    tick();
    #2 rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (cmd_done) nd++;
    end
    chk("rh_no_done", 32'(nd), 32'd0);
    chk("rh_pads_after", 32'(pads()), 32'(PADS_RST));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/modem_ctrl_sequencer.md
Name: modem_ctrl_sequencer

Overview:
Parametrised, multi-channel successor to the simple modem-status driver. Drives CTS/DSR/RI/DCD pad inputs of NUM_CH UART modem interfaces from a queued command stream. Each command updates a masked subset of one channel's lines and then holds them for a programmed number of cycles. Sits on the testbench/stimulus side of the UART pads and is clocked with the Wishbone clock.

Parameters:
NUM_CH, 2, number of modem channels (>=1)
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
HOLD_W, 16, width of the per-command hold counter
RESET_VAL, 4'b0000, reset value of {cts,dsr,ri,dcd} on every channel
CH_W (localparam), (NUM_CH>1)?$clog2(NUM_CH):1, width of channel index
LVL_W (localparam), $clog2(FIFO_DEPTH+1), width of fifo_level

Ports:
wb_clk_i  in  1  clock, rising edge
wb_rst_i  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_ch  in  CH_W  target channel
cmd_bits  in  4  new {cts,dsr,ri,dcd} values
cmd_mask  in  4  1 = update corresponding bit, 0 = keep
cmd_auto  in  1  enable auto-CTS on target channel (optional feature only)
cmd_hold  in  HOLD_W  hold cycles after apply
flush  in  1  drop queued commands, abort current hold
rts_pad_o  in  NUM_CH  RTS from DUT, per channel
cts_pad_i  out  NUM_CH  CTS to DUT
dsr_pad_i  out  NUM_CH  DSR to DUT
ri_pad_i  out  NUM_CH  RI to DUT
dcd_pad_i  out  NUM_CH  DCD to DUT
busy  out  1  state==HOLD or FIFO not empty
fifo_level  out  LVL_W  queued commands
cmd_done  out  1  one-cycle pulse when a command's hold expires
cmd_err  out  1  one-cycle pulse, coincident with cmd_done, for out-of-range cmd_ch

Behaviour:
- Reset (async, wb_rst_i=1): all pad outputs = RESET_VAL bits; FIFO empty; fifo_level=0; state IDLE; cmd_done=cmd_err=0; busy=0; auto-CTS disabled on all channels.
- cmd_ready = !full && !flush. Write on an edge with cmd_valid&&cmd_ready. Simultaneous write and pop on a full FIFO is not permitted (ready is low); on a non-full FIFO both occur and the level is unchanged.
- FSM states: IDLE, HOLD.
- IDLE: on an edge with FIFO non-empty, pop the head and, in that same edge, update masked bits of channel cmd_ch. Load cnt=cmd_hold and go to HOLD.
- Latency: a command written into an empty FIFO at edge k reaches the pads after edge k+1.
- HOLD: on each edge, if cnt==0, go to IDLE and pulse cmd_done for one cycle; else cnt--.
- Timing: a command popped at edge t pulses cmd_done after edge t+H+1, and the next pop occurs at edge t+H+2 at the earliest. Pads therefore hold for at least H+2 cycles.
- cmd_ch >= NUM_CH: command is popped and held normally, no pad changes, and cmd_err pulses with cmd_done.
- cmd_mask=0: pure delay command.
- Pointers wrap modulo FIFO_DEPTH.
- flush (synchronous, one edge): FIFO emptied, state forced to IDLE, cnt cleared, pads keep their current values, and no cmd_done for the aborted command. Flush takes priority over a concurrent write (cmd_ready is already low) and over a concurrent pop.
- Async reset mid-HOLD: immediate return to reset values; no cmd_done.

Optional Feature:
MODEM_AUTO_CTS_EN
- Defined: a command with cmd_auto=1 sets auto[cmd_ch] (cmd_auto=0 clears it). While auto[ch]=1, cts_pad_i[ch] = rts_pad_o[ch] passed through a 2-flop synchroniser (2-3 cycle lag), and command cts bits for that channel are ignored. Synchroniser flops reset to RESET_VAL[3].
- Undefined: cmd_auto and rts_pad_o are ignored; no synchroniser flops are instantiated; cts comes from commands only.

Test Plan:
- Reset: assert wb_rst_i mid-cycle -> all pads=RESET_VAL immediately; cmd_ready=1; fifo_level=0.
- Single command: ch=1, bits=4'b1010, mask=4'hF, hold=3 written at edge k -> cts[1]=1, dsr[1]=0, ri[1]=1, dcd[1]=0 after edge k+1; cmd_done after edge k+5; ch0 unchanged.
- Mask and back-to-back: write 5 commands with FIFO_DEPTH=4 and no pops blocking -> cmd_ready low when level=4; only masked bits change; consecutive applies are spaced hold+2 cycles.
- Out-of-range: NUM_CH=3, cmd_ch=3 -> no pad change; cmd_err and cmd_done pulse together.
- Flush: 3 commands queued, flush during the second command's HOLD with cmd_valid=1 -> level=0, the flush-cycle command is dropped, pads retain the second command's values, no cmd_done.
- MODEM_AUTO_CTS_EN defined: cmd_auto=1 on ch0, toggle rts_pad_o[0] -> cts_pad_i[0] follows 2-3 cycles later; a later cmd with cts=0 leaves CTS tracking RTS until cmd_auto=0.
